// File: rtl/rrf_free_list_pkg.sv
// Shared sizing and types for the rename register file free list.
// RRF_NUM must stay a power of two so tag arithmetic can wrap naturally.
package rrf_free_list_pkg;
  localparam int RRF_NUM      = 64;
  localparam int RRF_SEL      = 6;
  localparam int RRF_FREE_LEN = RRF_SEL + 1;

  typedef logic [RRF_SEL-1:0]      rrf_tag_t;
  typedef logic [RRF_FREE_LEN-1:0] rrf_cnt_t;

  localparam rrf_cnt_t RRF_FULL_CNT = rrf_cnt_t'(RRF_NUM);
endpackage

// File: rtl/rrf_free_list.sv
// RRF allocation/reclamation as a circular buffer: dispatch allocates at alloc_ptr,
// commit reclaims at com_ptr, and a flush rewinds alloc_ptr to the post-commit com_ptr.
module rrf_free_list
  import rrf_free_list_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [1:0]              alloc_req_i,
  input  logic [1:0]              commit_num_i,
  input  logic                    flush_i,
  output logic                    alloc_en1_o,
  output logic [RRF_SEL-1:0]      alloc_tag1_o,
  output logic                    alloc_en2_o,
  output logic [RRF_SEL-1:0]      alloc_tag2_o,
  output logic                    stall_o,
  output logic [RRF_SEL-1:0]      com_tag1_o,
  output logic [RRF_SEL-1:0]      com_tag2_o,
  output logic [RRF_FREE_LEN-1:0] free_num_o
);

  rrf_tag_t alloc_ptr_q, alloc_ptr_d;
  rrf_tag_t com_ptr_q, com_ptr_d;
  rrf_cnt_t free_num_q, free_num_d;

  logic       grant;
  logic [1:0] grant_num;

  // Grant is judged on the pre-update count, so entries freed this cycle
  // only become allocatable next cycle.
  always_comb begin
    grant     = !flush_i && (free_num_q >= rrf_cnt_t'(alloc_req_i));
    grant_num = grant ? alloc_req_i : 2'd0;
    com_ptr_d = com_ptr_q + rrf_tag_t'(commit_num_i);
    if (flush_i) begin
      alloc_ptr_d = com_ptr_d;
      free_num_d  = RRF_FULL_CNT;
    end else begin
      alloc_ptr_d = alloc_ptr_q + rrf_tag_t'(grant_num);
      free_num_d  = free_num_q - rrf_cnt_t'(grant_num) + rrf_cnt_t'(commit_num_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      alloc_ptr_q <= '0;
      com_ptr_q   <= '0;
      free_num_q  <= RRF_FULL_CNT;
    end else begin
      alloc_ptr_q <= alloc_ptr_d;
      com_ptr_q   <= com_ptr_d;
      free_num_q  <= free_num_d;
    end
  end

  // Outputs are forced to their reset image while reset is held, so the
  // RRF sees a clean idle interface even before the first reset edge.
  always_comb begin
    alloc_en1_o  = !reset_i && grant && (alloc_req_i != 2'd0);
    alloc_en2_o  = !reset_i && grant && (alloc_req_i == 2'd2);
    stall_o      = !reset_i && (alloc_req_i != 2'd0) && !grant;
    alloc_tag1_o = reset_i ? rrf_tag_t'(0) : alloc_ptr_q;
    alloc_tag2_o = reset_i ? rrf_tag_t'(1) : alloc_ptr_q + rrf_tag_t'(1);
    com_tag1_o   = reset_i ? rrf_tag_t'(0) : com_ptr_q;
    com_tag2_o   = reset_i ? rrf_tag_t'(1) : com_ptr_q + rrf_tag_t'(1);
    free_num_o   = reset_i ? RRF_FULL_CNT : free_num_q;
  end

  // Occupancy truncated to RRF_SEL bits is zero when full, matching equal pointers.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (alloc_req_i != 2'd3);
      assert (commit_num_i != 2'd3);
      assert (rrf_cnt_t'(commit_num_i) <= RRF_FULL_CNT - free_num_q);
      assert (free_num_q <= RRF_FULL_CNT);
      assert (rrf_tag_t'(alloc_ptr_q - com_ptr_q) == rrf_tag_t'(RRF_FULL_CNT - free_num_q));
    end
  end

endmodule
